// File: rtl/lab3a_pkg.sv
// Shared types and constants for the lab 3A response checker.
// Holds the sweep FSM encoding, the input/table sizes and the golden table.
package lab3a_pkg;

  localparam int N_IN = 4;
  localparam int TT_W = 16;

  // Golden truth table of the lab 3A function: bit k = f(ABCD=k)
  localparam logic [TT_W-1:0] LAB3A_GOLDEN = 16'hA5C3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/lab3a_response_checker_settle_counter.sv
// Hold counter for one stimulus vector.
// tc is asserted while the count equals SETTLE-1.
module settle_counter #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tc
);

  // With SETTLE=0 the caller bypasses the settle phase, so the value is irrelevant
  localparam logic [7:0] TC_VAL = (SETTLE == 0) ? 8'd0 : 8'(SETTLE - 1);

  logic [7:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + 8'd1;
    end
  end

  assign tc = (count == TC_VAL);

endmodule

// File: rtl/lab3a_response_checker.sv
// Sweeps all 16 ABCD vectors into the function block, records f into a
// measured truth table and compares it against a table latched at start.
module lab3a_response_checker
  import lab3a_pkg::*;
#(
  parameter int SETTLE = 2,
  parameter int N_IN   = lab3a_pkg::N_IN,
  parameter int TT_W   = lab3a_pkg::TT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            f,
  input  logic [TT_W-1:0] expected,
  output logic            A,
  output logic            B,
  output logic            C,
  output logic            D,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [TT_W-1:0] tt,
  output logic [N_IN:0]   mismatches
);

  localparam int             MM_W     = N_IN + 1;
  localparam logic [N_IN-1:0] LAST_IDX = '1;
  localparam logic [N_IN-1:0] IDX_ONE  = N_IN'(1);
  localparam logic [MM_W-1:0] MM_ONE   = MM_W'(1);

  state_t          state;
  logic [N_IN-1:0] index;
  logic [TT_W-1:0] exp_reg;
  logic            cnt_clear;
  logic            cnt_en;
  logic            cnt_tc;

  // The counter idles at zero everywhere except while a vector is settling
  assign cnt_clear = (state == ST_IDLE) || (state == ST_SAMPLE);
  assign cnt_en    = (state == ST_SETTLE);

  settle_counter #(
    .SETTLE (SETTLE)
  ) u_settle (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear),
    .en    (cnt_en),
    .tc    (cnt_tc)
  );

  // Stimulus comes straight from the index register, so A..D are registered
  assign {A, B, C, D} = index;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      index      <= '0;
      exp_reg    <= '0;
      tt         <= '0;
      mismatches <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            exp_reg    <= expected;
            tt         <= '0;
            mismatches <= '0;
            pass       <= 1'b0;
            index      <= '0;
            busy       <= 1'b1;
            if (SETTLE == 0) state <= ST_SAMPLE;
            else             state <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (cnt_tc) state <= ST_SAMPLE;
        end

        ST_SAMPLE: begin
          tt[index] <= f;
          if (f != exp_reg[index]) mismatches <= mismatches + MM_ONE;
          if (index == LAST_IDX) begin
            state <= ST_DONE;
          end else begin
            index <= index + IDX_ONE;
            if (SETTLE == 0) state <= ST_SAMPLE;
            else             state <= ST_SETTLE;
          end
        end

        ST_DONE: begin
          // Count already includes the index-15 compare from the previous edge
          done  <= 1'b1;
          busy  <= 1'b0;
          pass  <= (mismatches == '0);
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/lab3a_response_checker.md
# lab3a_response_checker

Sequential sweep-and-check engine for the 4-input combinational function block used in lab 3A. On `start` it drives all 16 input combinations on A/B/C/D in ascending order, samples the function output `f` for each one, and assembles the measured 16-entry truth table. It then compares that table against an expected table latched at `start` and reports pass/fail and the mismatch count. It sits beside the function block in synthesizable top-levels and replaces the hand-written stimulus sequence with a hardware checker.

## Interface

Parameters:
- `SETTLE`, default 2: cycles each input vector is held before `f` is sampled; legal range 0..255.
- `N_IN`, default 4: number of function inputs; fixed at 4 for this revision.
- `TT_W`, default 16: truth-table width, equal to 2**N_IN.

Ports:
- `clk`  in  1  sole clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a sweep; accepted only in IDLE.
- `f`  in  1  function output returned from the block under check.
- `expected`  in  TT_W  golden truth table, bit k = f(ABCD=k); latched when `start` is accepted.
- `A`, `B`, `C`, `D`  out  1 each  stimulus; A is the MSB of the vector index, D the LSB.
- `busy`  out  1  high from accept through the last sample.
- `done`  out  1  one-cycle pulse when results become valid.
- `pass`  out  1  high when the measured table equals `expected`; held until the next accept.
- `tt`  out  TT_W  measured truth table; held until the next accept.
- `mismatches`  out  N_IN+1  count of differing bits, 0..16; held until the next accept.

## Operation

- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: outputs hold their last results.
  - `start`=1 performs the following: latch `expected`, clear `tt` and `mismatches`, set `pass`=0, set index=0, set hold counter=0, and go to SETTLE. If SETTLE=0, go directly to SAMPLE instead.
- SETTLE: A..D = index. Increment the hold counter each cycle. Go to SAMPLE when the counter reaches SETTLE-1.
- SAMPLE: A..D = index.
  - Write `f` into `tt[index]`.
  - If `f` differs from `expected[index]`, increment `mismatches`.
  - If index=15, go to DONE. Otherwise increment index, clear the hold counter, and go to SETTLE (or stay in SAMPLE when SETTLE=0).
- DONE: `done`=1 for this cycle only.
  - `pass` = (`mismatches`==0), computed from the final registered count including the index-15 compare.
  - Go to IDLE.
- `start` while busy or in DONE is ignored; the sweep is never restarted or extended.
- Index is 4 bits and never wraps mid-sweep; the transition at 15 is to DONE.
- `expected` may change after accept with no effect on the current sweep.

## Timing

- Reset values:
  - state = IDLE.
  - A, B, C, D = 0.
  - `busy` = 0, `done` = 0, `pass` = 0.
  - `tt` = 16'h0000, `mismatches` = 0.
- Reset asserted mid-sweep aborts immediately to these values. No `done` is issued for the aborted sweep.
- Each vector occupies SETTLE+1 cycles.
- Let edge 0 be the accepting edge. Vector k is driven from edge 1+k·(SETTLE+1).
- `f` is sampled at the last edge of vector k. `f` must be stable SETTLE cycles after A..D change; with SETTLE=0, `f` must be combinationally valid in the same cycle.
- `done` is high during the cycle after edge 1+16·(SETTLE+1). Example: SETTLE=2 puts `done` at edge 49.
- `busy` falls with `done` rising.
- `start` held high through DONE is not accepted until the state is back in IDLE, i.e. the cycle after `done`.
- All outputs are registered; there are no combinational paths from input to output.

## Structure

- Shared package `lab3a_pkg`:
  - State enum: IDLE, SETTLE, SAMPLE, DONE.
  - Constants N_IN=4 and TT_W=16.
  - Lab 3A golden truth-table constant, used by top-level and bench.
- One natural sub-module, `settle_counter`: a hold counter with parameter SETTLE and a terminal-count output.
- Index counter, truth-table register, and compare logic live in the top module.

## Test plan

- **Matching function.** Use a model where f = table lookup of 16'hA5C3 and set `expected`=16'hA5C3 with SETTLE=2. Required: `tt`=16'hA5C3, `mismatches`=0, `pass`=1, and `done` at edge 49.
- **Inverted model.** Use a model returning the inverse of 16'hA5C3 with `expected`=16'hA5C3. Required: `tt`=16'h5A3C, `mismatches`=16, `pass`=0.
- **Single-bit fault.** Use a model that differs only at ABCD=4'b1101 with SETTLE=0. Required: `mismatches`=1, `tt[13]` flipped, `pass`=0, and `done` at edge 17.
- **Ordering.** Monitor A..D during the sweep. Required: the sequence is 0000 through 1111 ascending, each vector held exactly SETTLE+1 cycles, with no repeats and no skips.
- **Spurious start.** Pulse `start` mid-sweep and change `expected`. Required: there is no restart, results match the originally latched `expected`, and exactly one `done` is issued.
- **Reset mid-sweep.** Assert `rst` at vector 7. Required: all outputs return to reset values immediately, and no `done` is issued. A new `start` then completes a full, correct sweep.
